// File: rtl/histogram_equalization_map_pkg.sv
// Shared definitions for the histogram equalization mapper.
//   HEM_DW      : default pixel width
//   HEM_DCNT    : default number of grey levels / LUT entries
//   HEM_CNT_DW  : default histogram count / CDF width
//   hem_state_e : table-build FSM state encoding (also exported for debug)
package histogram_equalization_map_pkg;

  localparam int HEM_DW     = 8;
  localparam int HEM_DCNT   = 1 << HEM_DW;
  localparam int HEM_CNT_DW = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_LOAD  = 3'd2,
    S_ITER  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } hem_state_e;

endpackage

// File: rtl/hist_eq_divider.sv
// Sequential restoring divider producing a DW-bit quotient, one bit per cycle,
// MSB first.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   start_i       : load dividend_i / divisor_i and begin a division
//   dividend_i    : CNT_DW+DW bit dividend
//   divisor_i     : CNT_DW bit divisor
//   done_o        : high during the cycle that computes the last quotient bit
//   quotient_o    : result, valid from the cycle after done_o until next start
//
// Handshake: start_i is a single-cycle request sampled at the clock edge; the
// caller must not raise it again before done_o. done_o is asserted in the DW-th
// cycle after start_i was sampled, so the caller can leave its wait state at the
// same edge that stores the final bit and read quotient_o on the next cycle.
//
// The caller guarantees the quotient fits in DW bits (dividend < divisor << DW),
// so the upper CNT_DW dividend bits are already a valid partial remainder and
// only the low DW bits need iterating. A zero divisor yields a zero quotient.
module hist_eq_divider #(
  parameter int DW     = 8,
  parameter int CNT_DW = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [CNT_DW+DW-1:0] dividend_i,
  input  logic [CNT_DW-1:0]    divisor_i,
  output logic                 done_o,
  output logic [DW-1:0]        quotient_o
);

  localparam int CW = $clog2(DW + 1);

  logic [CNT_DW-1:0] rem_q;
  logic [CNT_DW-1:0] dsr_q;
  logic [DW-1:0]     dvd_q;
  logic [DW-1:0]     quo_q;
  logic [CW-1:0]     cnt_q;
  logic              zero_q;

  logic [CNT_DW:0]   trial;
  logic [CNT_DW:0]   diff;
  logic              take;

  // Shift the next dividend bit into the partial remainder and try a subtract.
  assign trial = {rem_q, dvd_q[DW-1]};
  assign diff  = trial - {1'b0, dsr_q};
  assign take  = (trial >= {1'b0, dsr_q});

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rem_q  <= '0;
      dsr_q  <= '0;
      dvd_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      zero_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= dividend_i[CNT_DW+DW-1:DW];
      dvd_q  <= dividend_i[DW-1:0];
      dsr_q  <= divisor_i;
      zero_q <= (divisor_i == '0);
      quo_q  <= '0;
      cnt_q  <= CW'(DW);
    end else if (cnt_q != '0) begin
      // When the subtract is rejected trial < divisor, so its top bit is 0.
      rem_q <= take ? diff[CNT_DW-1:0] : trial[CNT_DW-1:0];
      dvd_q <= {dvd_q[DW-2:0], 1'b0};
      quo_q <= {quo_q[DW-2:0], take};
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign done_o     = (cnt_q == CW'(1));
  assign quotient_o = zero_q ? '0 : quo_q;

endmodule

// File: rtl/histogram_equalization_map.sv
// Histogram equalization mapper.
// Accumulates the per-frame histogram stream into a CDF, builds an
// equalization LUT (lut[v] = floor(cdf[v]*(DCNT-1)/total)) into the inactive
// bank of a double-buffered table, and remaps the live grey video through the
// active bank. A finished table becomes active on the next src_vsync rise.
//   pclk, rst_n       : pixel clock, synchronous active-low reset
//   hs_valid/hs_pixel/hs_pixel_cnt : histogram entries, grey 0..DCNT-1 in order
//   src_hsync/src_vsync/src_data   : source video
//   dst_hsync/dst_vsync/dst_data   : remapped video, 1 cycle latency
//   lut_busy          : table build in progress
//   lut_done          : one-cycle pulse, new table written to inactive bank
//   lut_valid         : at least one table has been made active
//   dbg_state         : build FSM state
module histogram_equalization_map
  import histogram_equalization_map_pkg::*;
#(
  parameter int DW     = HEM_DW,
  parameter int DCNT   = HEM_DCNT,
  parameter int CNT_DW = HEM_CNT_DW
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              hs_valid,
  input  logic [DW-1:0]     hs_pixel,
  input  logic [CNT_DW-1:0] hs_pixel_cnt,
  input  logic              src_hsync,
  input  logic              src_vsync,
  input  logic [DW-1:0]     src_data,
  output logic              dst_hsync,
  output logic              dst_vsync,
  output logic [DW-1:0]     dst_data,
  output logic              lut_busy,
  output logic              lut_done,
  output logic              lut_valid,
  output hem_state_e        dbg_state
);

  localparam int PW = CNT_DW + DW;

  logic [CNT_DW-1:0] cdf_q [DCNT];
  logic [DW-1:0]     lut_q [2][DCNT];

  hem_state_e        state_q;
  logic [DW-1:0]     idx_q;
  logic [DW-1:0]     ent_q;
  logic [CNT_DW-1:0] acc_q;
  logic [CNT_DW-1:0] total_q;
  logic              pending_q;
  logic              active_q;
  logic              lut_valid_q;
  logic              dst_hsync_q;
  logic              dst_vsync_q;
  logic [DW-1:0]     dst_data_q;

  logic              active_d;
  logic              lut_valid_d;
  logic              vs_rise;
  logic              swap;
  logic              hist_start;
  logic              hist_accept;
  logic [CNT_DW-1:0] acc_nxt;
  logic              wr_bank;

  logic              div_start;
  logic              div_done;
  logic [PW-1:0]     div_dividend;
  logic [DW-1:0]     div_quotient;

  // dst_vsync_q is src_vsync from the previous cycle, so it doubles as the
  // edge detector history.
  assign vs_rise = src_vsync & ~dst_vsync_q;

  // A table finishing this cycle (DONE) counts as pending, so a coincident
  // vsync rise swaps it in immediately.
  assign swap        = vs_rise & (pending_q | (state_q == S_DONE));
  assign active_d    = active_q ^ swap;
  assign lut_valid_d = lut_valid_q | swap;

  assign hist_start  = (state_q == S_IDLE) && hs_valid && (hs_pixel == '0);
  assign hist_accept = (state_q == S_ACCUM) && hs_valid && (hs_pixel == idx_q);
  assign acc_nxt     = acc_q + hs_pixel_cnt;
  assign wr_bank     = ~active_q;

  assign div_start    = (state_q == S_LOAD);
  assign div_dividend = PW'(cdf_q[ent_q]) * PW'(DCNT - 1);

  hist_eq_divider #(
    .DW     (DW),
    .CNT_DW (CNT_DW)
  ) u_div (
    .clk_i      (pclk),
    .rst_ni     (rst_n),
    .start_i    (div_start),
    .dividend_i (div_dividend),
    .divisor_i  (total_q),
    .done_o     (div_done),
    .quotient_o (div_quotient)
  );

  // Build FSM plus bank bookkeeping.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      ent_q       <= '0;
      acc_q       <= '0;
      total_q     <= '0;
      pending_q   <= 1'b0;
      active_q    <= 1'b0;
      lut_valid_q <= 1'b0;
    end else begin
      active_q    <= active_d;
      lut_valid_q <= lut_valid_d;
      if (swap) pending_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (hist_start) begin
            // A new build overwrites the inactive bank, so any finished but
            // not yet swapped table is dropped.
            pending_q <= 1'b0;
            acc_q     <= hs_pixel_cnt;
            idx_q     <= DW'(1);
            state_q   <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (hist_accept) begin
            acc_q <= acc_nxt;
            if (idx_q == DW'(DCNT - 1)) begin
              total_q <= acc_nxt;
              ent_q   <= '0;
              state_q <= S_LOAD;
            end else begin
              idx_q <= idx_q + DW'(1);
            end
          end else begin
            // Broken or out-of-order stream: abandon it without touching banks.
            state_q <= S_IDLE;
          end
        end
        S_LOAD: state_q <= S_ITER;
        S_ITER: begin
          if (div_done) state_q <= S_WRITE;
        end
        S_WRITE: begin
          if (ent_q == DW'(DCNT - 1)) begin
            state_q <= S_DONE;
          end else begin
            ent_q   <= ent_q + DW'(1);
            state_q <= S_LOAD;
          end
        end
        S_DONE: begin
          pending_q <= ~swap;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // CDF buffer (no reset: contents are only read after a full stream).
  always_ff @(posedge pclk) begin
    if (rst_n) begin
      if (hist_start)       cdf_q[0]     <= hs_pixel_cnt;
      else if (hist_accept) cdf_q[idx_q] <= acc_nxt;
    end
  end

  // LUT banks: the build only ever writes the inactive bank.
  always_ff @(posedge pclk) begin
    if (rst_n && (state_q == S_WRITE)) lut_q[wr_bank][ent_q] <= div_quotient;
  end

  // Video path: map through the bank that is active after this cycle's swap.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      dst_hsync_q <= 1'b0;
      dst_vsync_q <= 1'b0;
      dst_data_q  <= '0;
    end else begin
      dst_hsync_q <= src_hsync;
      dst_vsync_q <= src_vsync;
      if (!src_hsync)       dst_data_q <= '0;
      else if (lut_valid_d) dst_data_q <= lut_q[active_d][src_data];
      else                  dst_data_q <= src_data;
    end
  end

  assign dst_hsync = dst_hsync_q;
  assign dst_vsync = dst_vsync_q;
  assign dst_data  = dst_data_q;
  assign lut_busy  = (state_q != S_IDLE);
  assign lut_done  = (state_q == S_DONE);
  assign lut_valid = lut_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_histogram_equalization_map.sv
// Self-checking bench for histogram_equalization_map: a reference model
// computes each equalization table from the histogram with plain arithmetic;
// every driven active pixel pushes its expected mapped value, and a monitor
// pops and compares whenever the DUT presents dst_hsync.
module tb_histogram_equalization_map;
  import histogram_equalization_map_pkg::*;

  localparam int DW           = HEM_DW;
  localparam int DCNT         = HEM_DCNT;
  localparam int CNT_DW       = HEM_CNT_DW;
  localparam int BUILD_CYCLES = DCNT * (DW + 2);
  localparam int WAIT_LIMIT   = BUILD_CYCLES + 500;

  // ---------------- clock / reset ----------------
  logic pclk  = 1'b0;
  logic rst_n = 1'b0;
  always #5 pclk = ~pclk;

  logic              hs_valid = 1'b0;
  logic [DW-1:0]     hs_pixel = '0;
  logic [CNT_DW-1:0] hs_pixel_cnt = '0;
  logic              src_hsync = 1'b0;
  logic              src_vsync = 1'b0;
  logic [DW-1:0]     src_data = '0;
  logic              dst_hsync, dst_vsync, lut_busy, lut_done, lut_valid;
  logic [DW-1:0]     dst_data;
  hem_state_e        dbg_state;

  histogram_equalization_map #(.DW(DW), .DCNT(DCNT), .CNT_DW(CNT_DW)) dut (
    .pclk         (pclk),
    .rst_n        (rst_n),
    .hs_valid     (hs_valid),
    .hs_pixel     (hs_pixel),
    .hs_pixel_cnt (hs_pixel_cnt),
    .src_hsync    (src_hsync),
    .src_vsync    (src_vsync),
    .src_data     (src_data),
    .dst_hsync    (dst_hsync),
    .dst_vsync    (dst_vsync),
    .dst_data     (dst_data),
    .lut_busy     (lut_busy),
    .lut_done     (lut_done),
    .lut_valid    (lut_valid),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int            vectors     = 0;
  int            miscompares = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_v;
  bit            mon_en = 1'b0;

  // ---------------- reference model ----------------
  int unsigned   hist     [DCNT];
  logic [DW-1:0] m_built  [DCNT];
  logic [DW-1:0] m_pend   [DCNT];
  logic [DW-1:0] m_act    [DCNT];
  bit            m_valid, m_pending, m_prev_vs;

  function automatic void build_model();
    longint unsigned run;
    longint unsigned cdf [DCNT];
    run = 0;
    for (int v = 0; v < DCNT; v++) begin
      run    += hist[v];
      cdf[v]  = run;
    end
    for (int v = 0; v < DCNT; v++)
      m_built[v] = (run == 0) ? '0 : DW'((cdf[v] * (DCNT - 1)) / run);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge pclk) begin
    if (mon_en && dst_hsync === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL map: got unexpected pixel %0d, expected none (t=%0t)", dst_data, $time);
      end else begin
        exp_v = exp_q.pop_front();
        check("map", dst_data, exp_v);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // One clock of stimulus; the model applies the swap rule for this edge.
  task automatic cycle(input bit hv, input int hp, input int unsigned hc,
                       input bit sh, input bit sv, input logic [DW-1:0] sd);
    hs_valid     = hv;
    hs_pixel     = DW'(hp);
    hs_pixel_cnt = hc;
    src_hsync    = sh;
    src_vsync    = sv;
    src_data     = sd;
    if (sv && !m_prev_vs && m_pending) begin
      m_act     = m_pend;
      m_valid   = 1'b1;
      m_pending = 1'b0;
    end
    m_prev_vs = sv;
    if (sh) exp_q.push_back(m_valid ? m_act[sd] : sd);
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 0, 0, 1'b0, 1'b0, '0);
  endtask

  task automatic pix(input logic [DW-1:0] d);
    cycle(1'b0, 0, 0, 1'b1, 1'b0, d);
  endtask

  task automatic sweep();
    for (int v = 0; v < DCNT; v++) pix(DW'(v));
    repeat (40) cycle(1'b0, 0, 0, 1'($urandom_range(0, 1)), 1'b0, DW'($urandom_range(0, DCNT - 1)));
  endtask

  task automatic vsync_pulse();
    cycle(1'b0, 0, 0, 1'b0, 1'b1, '0);
    idle(1);
  endtask

  // Stream the histogram in order; at stop_at the entry is dropped (hs_valid=0).
  task automatic send_hist(input int stop_at);
    for (int v = 0; v < DCNT; v++) begin
      if (v == stop_at) begin
        cycle(1'b0, v, hist[v], 1'b0, 1'b0, '0);
        break;
      end
      cycle(1'b1, v, hist[v], 1'b0, 1'b0, '0);
    end
  endtask

  // Clock edges after the last entry until lut_done is seen, bounded.
  task automatic wait_done(output int k);
    k = 0;
    while (lut_done !== 1'b1 && k < WAIT_LIMIT) begin
      idle(1);
      k++;
    end
    check("lut_done_seen", lut_done, 1);
  endtask

  task automatic idle_watch(input int n, output bit saw);
    saw = 1'b0;
    repeat (n) begin
      idle(1);
      if (lut_done === 1'b1) saw = 1'b1;
    end
  endtask

  task automatic random_hist();
    for (int v = 0; v < DCNT; v++)
      hist[v] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 200);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    hs_valid     = 1'b1;
    hs_pixel     = '0;
    hs_pixel_cnt = 32'd5;
    src_hsync    = 1'b1;
    src_vsync    = 1'b1;
    src_data     = DW'($urandom);
    step();
    check("rst_dst_hsync", dst_hsync, 0);
    check("rst_dst_vsync", dst_vsync, 0);
    check("rst_dst_data", dst_data, 0);
    check("rst_lut_busy", lut_busy, 0);
    check("rst_lut_done", lut_done, 0);
    check("rst_lut_valid", lut_valid, 0);
    check("rst_state", dbg_state, S_IDLE);
    rst_n     = 1'b1;
    hs_valid  = 1'b0;
    src_hsync = 1'b0;
    src_vsync = 1'b0;
    src_data  = '0;
    m_valid   = 1'b0;
    m_pending = 1'b0;
    m_prev_vs = 1'b0;
  endtask

  task automatic commit_pending();
    m_pend    = m_built;
    m_pending = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int        k;
    int        pre;
    bit        saw;
    do_reset();
    mon_en = 1'b1;

    // Identity mapping before any table; blanking forces 0; syncs delayed.
    pix(DW'(37));
    check("pre_identity", dst_data, 37);
    check("pre_lut_valid", lut_valid, 0);
    cycle(1'b0, 0, 0, 1'b0, 1'b0, DW'(37));
    check("blank_zero", dst_data, 0);
    check("blank_hsync", dst_hsync, 0);
    cycle(1'b0, 0, 0, 1'b0, 1'b1, '0);
    check("vsync_delay_hi", dst_vsync, 1);
    idle(1);
    check("vsync_delay_lo", dst_vsync, 0);
    repeat (20) pix(DW'($urandom_range(0, DCNT - 1)));

    // Single spike at 100: below maps to 0, at/above to 255.
    foreach (hist[v]) hist[v] = 0;
    hist[100] = 64;
    build_model();
    send_hist(-1);
    check("busy_after_stream", lut_busy, 1);
    wait_done(k);
    check("build_latency", k, BUILD_CYCLES);
    commit_pending();
    idle(1);
    check("done_one_pulse", lut_done, 0);
    check("busy_after_done", lut_busy, 0);
    check("valid_before_vsync", lut_valid, 0);
    vsync_pulse();
    check("valid_after_vsync", lut_valid, 1);
    pix(DW'(100));
    check("spike_at_100", dst_data, 255);
    pix(DW'(99));
    check("spike_at_99", dst_data, 0);
    sweep();

    // Uniform histogram, 4 per level.
    foreach (hist[v]) hist[v] = 4;
    build_model();
    send_hist(-1);
    wait_done(k);
    check("build_latency_uniform", k, BUILD_CYCLES);
    commit_pending();
    idle(2);
    vsync_pulse();
    pix(DW'(0));
    check("uniform_lut0", dst_data, 0);
    pix(DW'(127));
    check("uniform_lut127", dst_data, 127);
    pix(DW'(255));
    check("uniform_lut255", dst_data, 255);
    sweep();

    // Stream broken at 50: abandoned, old table stays in use.
    random_hist();
    send_hist(50);
    check("abort_busy", lut_busy, 0);
    check("abort_state", dbg_state, S_IDLE);
    idle_watch(BUILD_CYCLES + 50, saw);
    check("abort_no_done", saw, 0);
    vsync_pulse();
    sweep();

    // Second stream arriving mid-build is ignored.
    random_hist();
    build_model();
    send_hist(-1);
    idle(20);
    check("busy_mid_build", lut_busy, 1);
    random_hist();
    send_hist(-1);
    wait_done(k);
    check("build_latency_ignored", k + 20 + DCNT, BUILD_CYCLES);
    commit_pending();
    idle(2);
    vsync_pulse();
    sweep();

    // Reset during ITER: outputs cleared, identity mapping, partial table gone.
    random_hist();
    send_hist(-1);
    idle(30);
    repeat (5) pix(DW'($urandom_range(0, DCNT - 1)));
    idle(1);
    do_reset();
    repeat (10) pix(DW'($urandom_range(0, DCNT - 1)));
    idle_watch(BUILD_CYCLES, saw);
    check("reset_no_done", saw, 0);
    vsync_pulse();
    check("reset_valid_stays_0", lut_valid, 0);
    repeat (20) pix(DW'($urandom_range(0, DCNT - 1)));

    // lut_done and vsync rise in the same cycle: swap takes effect at once.
    random_hist();
    build_model();
    send_hist(-1);
    wait_done(k);
    check("build_latency_sameedge", k, BUILD_CYCLES);
    commit_pending();
    cycle(1'b0, 0, 0, 1'b1, 1'b1, DW'($urandom_range(0, DCNT - 1)));
    check("sameedge_valid", lut_valid, 1);
    check("sameedge_done_gone", lut_done, 0);
    idle(1);
    sweep();

    // Empty histogram: total 0 gives an all-zero table.
    foreach (hist[v]) hist[v] = 0;
    build_model();
    send_hist(-1);
    wait_done(k);
    commit_pending();
    idle(2);
    vsync_pulse();
    sweep();

    idle(3);
    pre = exp_q.size();
    check("scoreboard_drained", pre, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
